led_matrix_scanner: RTL and testbench
=====================================

// Module: led_matrix_scanner
// PURPOSE
//   Scans a 4x4 LED matrix with per-pixel PWM brightness. Drives aled (anode row select) and
//   kled_tri (cathode SB_IO output enables); a kled_tri bit of 1 lights that column.
//   Uses a double-buffered frame store: the producer writes the back buffer, and a
//   swap_req/swap_ack handshake exchanges the buffers at a frame boundary.
//   Sits between pattern logic and the kled SB_IO cells in top; runs on the SB_HFOSC 48 MHz clk.
// PARAMETERS
//   BRIGHT_W  4   bits per pixel; a PWM step has 2^BRIGHT_W-1 on-slots (0=off, max=always on)
//   TICK_DIV  64  clk cycles per PWM slot (>=2); prescaler counts 0..TICK_DIV-1
// PORTS
//   clk        in   1         48 MHz clock
//   rst_n      in   1         async active-low reset
//   wr_en      in   1         write strobe into back buffer
//   wr_addr    in   4         pixel address {row[1:0],col[1:0]}
//   wr_data    in   BRIGHT_W  pixel brightness
//   swap_req   in   1         level; held high until swap_ack seen
//   swap_ack   out  1         1-cycle pulse: buffers exchanged
//   frame_start out 1         1-cycle pulse when row 0 drive begins
//   aled       out  4         one-hot row select, active high
//   kled_tri   out  4         column enables, active high
// BEHAVIOUR
//   Reset (async assert, sync-released use): both buffers all-zero, front=buf0, row=0,
//     state=BLANK, prescaler=0, slot=0; aled=0, kled_tri=0, swap_ack=0, frame_start=0.
//   Prescaler: tick asserted when prescaler==TICK_DIV-1, then wraps to 0. All state advances on tick.
//   FSM BLANK: aled=0, kled_tri=0 for exactly one slot (TICK_DIV cycles; anti-ghosting).
//     On tick -> DRIVE, slot=0, row advances (3 wraps to 0). If new row==0, pulse frame_start
//     in the cycle that DRIVE is entered.
//   FSM DRIVE: aled=onehot(row); kled_tri[c] = (slot < front[row][c]), unsigned compare.
//     slot counts 0..2^BRIGHT_W-2 on ticks; on tick at slot==2^BRIGHT_W-2 -> BLANK.
//   Row period: 2^BRIGHT_W slots = 2^BRIGHT_W*TICK_DIV cycles; frame = 4x that (4096 clk default).
//   The first DRIVE after reset is row 1 (BLANK exits by incrementing row); row 0 follows 3 rows later.
//   aled/kled_tri are registered: they change 1 clk after the tick edge that causes the change.
//   Swap: evaluated only on the tick leaving BLANK while row==3 (frame boundary). If swap_req=1,
//     front/back exchange, and swap_ack pulses the same cycle; the new front is used from row 0 on.
//     swap_req falling before the boundary: no swap. Held high after ack: next swap at next boundary.
//   Writes: wr_en writes back buffer in 1 cycle; the front buffer is never written.
//     wr_en in the swap cycle lands in the pre-swap back buffer (now front); it is visible.
//   Brightness max (all ones): on for all 2^BRIGHT_W-1 slots, dark only in BLANK. Zero: never on.
//   Reset mid-frame: outputs go to 0 immediately (async) and buffer contents are cleared.
// TESTING  (TICK_DIV=2, BRIGHT_W=4 unless stated)
//   1 Reset release, no writes, 2 frames -> aled cycles 0010,0100,1000,0001 with BLANK gaps;
//     kled_tri stays 0; frame_start period 128 clk.
//   2 Write pixel(1,2)=8, swap -> in row-1 DRIVE, kled_tri=0100 for 8 slots (16 clk), then 0
//     for 7 slots; aled=0010 throughout the drive.
//   3 Write all pixels=15, swap -> kled_tri=1111 for 30 clk per row; 0 during each 2-clk BLANK.
//   4 Raise swap_req mid-row-1 -> swap_ack only on the row-3 BLANK exit tick; old image persists
//     until the next frame_start.
//   5 wr_en to the back buffer in the exact swap_ack cycle -> data appears in the displayed frame.
//   6 Assert rst_n=0 mid-DRIVE -> aled=kled_tri=0 at once; after release, all pixels dark, sequence restarts per test 1.

Source files
------------

// File: rtl/led_matrix_scanner.sv
// 4x4 LED matrix scanner with per-pixel PWM and a double-buffered frame store.
// Latency: aled/kled_tri follow state 1 clk after each tick; no backpressure, buffer swap via level req / pulse ack.
module led_matrix_scanner #(
    parameter int BRIGHT_W = 4,
    parameter int TICK_DIV = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [3:0]          wr_addr,
    input  logic [BRIGHT_W-1:0] wr_data,
    input  logic                swap_req,
    output logic                swap_ack,
    output logic                frame_start,
    output logic [3:0]          aled,
    output logic [3:0]          kled_tri
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]       PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [BRIGHT_W-1:0] SLOT_LAST = BRIGHT_W'((1 << BRIGHT_W) - 2);

    typedef enum logic {BLANK, DRIVE} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       pre;
    logic                tick;
    logic                leave_blank;
    logic [1:0]          row;
    logic [BRIGHT_W-1:0] slot;
    logic                front_sel;
    logic [BRIGHT_W-1:0] buf0 [16];
    logic [BRIGHT_W-1:0] buf1 [16];
    logic [BRIGHT_W-1:0] pix;
    logic [3:0]          aled_nxt;
    logic [3:0]          kled_nxt;
    logic                frame_start_nxt;

    assign tick        = (pre == PRE_LAST);
    assign leave_blank = tick && (state == BLANK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
        end else begin
            pre <= tick ? '0 : pre + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BLANK;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (tick) begin
            case (state)
                BLANK:   state_nxt = DRIVE;
                DRIVE:   if (slot == SLOT_LAST) state_nxt = BLANK;
                default: state_nxt = BLANK;
            endcase
        end
    end

    // Swap only at the frame boundary, i.e. the BLANK exit that rolls row 3 over to row 0.
    always_comb begin
        aled_nxt        = '0;
        kled_nxt        = '0;
        pix             = '0;
        swap_ack        = leave_blank && (row == 2'd3) && swap_req;
        frame_start_nxt = leave_blank && (row == 2'd3);
        if (state == DRIVE) begin
            aled_nxt = 4'b0001 << row;
            for (int c = 0; c < 4; c++) begin
                pix         = front_sel ? buf1[{row, 2'(c)}] : buf0[{row, 2'(c)}];
                kled_nxt[c] = (slot < pix);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row         <= '0;
            slot        <= '0;
            front_sel   <= 1'b0;
            frame_start <= 1'b0;
            aled        <= '0;
            kled_tri    <= '0;
        end else begin
            if (tick) begin
                if (state == BLANK) begin
                    row  <= row + 2'd1;
                    slot <= '0;
                end else if (slot != SLOT_LAST) begin
                    slot <= slot + BRIGHT_W'(1);
                end
            end
            if (swap_ack) begin
                front_sel <= ~front_sel;
            end
            frame_start <= frame_start_nxt;
            aled        <= aled_nxt;
            kled_tri    <= kled_nxt;
        end
    end

    // Write target uses the pre-swap selection, so a write in the swap cycle lands in the new front.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                buf0[i] <= '0;
                buf1[i] <= '0;
            end
        end else if (wr_en) begin
            if (front_sel) begin
                buf0[wr_addr] <= wr_data;
            end else begin
                buf1[wr_addr] <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Bench for led_matrix_scanner: directed scenarios plus random writes/swaps against a slot-arithmetic model.
module tb_led_matrix_scanner;

    localparam int BW   = 4;
    localparam int TD   = 2;
    localparam int RP   = 1 << BW;
    localparam int FR   = 4 * RP;
    localparam int FS_S = 3 * RP + 1;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          wr_en    = 1'b0;
    logic [3:0]    wr_addr  = '0;
    logic [BW-1:0] wr_data  = '0;
    logic          swap_req = 1'b0;
    logic          swap_ack;
    logic          frame_start;
    logic [3:0]    aled;
    logic [3:0]    kled_tri;

    led_matrix_scanner #(.BRIGHT_W(BW), .TICK_DIV(TD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_start(frame_start),
        .aled       (aled),
        .kled_tri   (kled_tri)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;
    int t   = 0;
    int front_m [16];
    int back_m  [16];
    bit last_ack = 1'b0;
    int cnt;

    // Slot s (ticks since reset): s%RP==0 is BLANK, else DRIVE slot s%RP-1 on row (s/RP+1)%4.
    function automatic bit swap_edge(int tt);
        return (tt > 0) && (tt % TD == 0) && ((tt / TD) % FR == FS_S);
    endfunction

    function automatic logic [3:0] exp_aled(int s);
        if (s % RP == 0) return 4'b0000;
        return 4'b0001 << ((s / RP + 1) % 4);
    endfunction

    function automatic logic [3:0] exp_kled(int s);
        logic [3:0] k = 4'b0000;
        int p = s % RP;
        int r = (s / RP + 1) % 4;
        if (p != 0) begin
            for (int c = 0; c < 4; c++) k[c] = ((p - 1) < front_m[r * 4 + c]);
        end
        return k;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [3:0] ea, ek;
        logic       eack, ef;
        int         tmp [16];
        #1;
        eack = swap_req && swap_edge(t + 1);
        chk("swap_ack", 32'(swap_ack), 32'(eack));
        ea = exp_aled(t / TD);
        ek = exp_kled(t / TD);
        ef = swap_edge(t + 1);
        last_ack = eack;
        @(posedge clk);
        t++;
        if (wr_en) back_m[wr_addr] = int'(wr_data);
        if (swap_edge(t) && swap_req) begin
            tmp = front_m;
            front_m = back_m;
            back_m = tmp;
        end
        @(negedge clk);
        chk("aled", 32'(aled), 32'(ea));
        chk("kled_tri", 32'(kled_tri), 32'(ek));
        chk("frame_start", 32'(frame_start), 32'(ef));
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        swap_req = 1'b0;
        wr_en = 1'b0;
        #1;
        chk("rst_aled", 32'(aled), 32'd0);
        chk("rst_kled_tri", 32'(kled_tri), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_swap_ack", 32'(swap_ack), 32'd0);
        for (int i = 0; i < 16; i++) begin
            front_m[i] = 0;
            back_m[i] = 0;
        end
        @(negedge clk);
        rst_n = 1'b1;
        t = 0;
    endtask

    task automatic write_px(int addr, int val);
        wr_en = 1'b1;
        wr_addr = 4'(addr);
        wr_data = BW'(val);
        step();
        wr_en = 1'b0;
    endtask

    task automatic swap_wait(int maxc);
        swap_req = 1'b1;
        last_ack = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            step();
            if (last_ack) break;
        end
        chk("swap_ack_seen", 32'(last_ack), 32'd1);
        swap_req = 1'b0;
    endtask

    initial begin
        // Idle after reset: rows scan 1,2,3,0 with dark columns.
        do_reset();
        run(2 * FR * TD + 8);

        // Single pixel (1,2)=8 lights column 2 for 8 slots of row 1.
        write_px(6, 8);
        swap_wait(FR * TD + 8);
        cnt = 0;
        for (int i = 0; i < FR * TD; i++) begin
            step();
            if (kled_tri === 4'b0100 && aled === 4'b0010) cnt++;
        end
        chk("px12_lit_cycles", 32'(cnt), 32'(8 * TD));

        // Full brightness: every column lit for 15 slots per row.
        for (int a = 0; a < 16; a++) write_px(a, 15);
        swap_wait(FR * TD + 8);
        cnt = 0;
        for (int i = 0; i < FR * TD; i++) begin
            step();
            if (kled_tri === 4'b1111) cnt++;
        end
        chk("full_lit_cycles", 32'(cnt), 32'(4 * (RP - 1) * TD));

        // Request dropped before the boundary: no swap.
        for (int a = 0; a < 16; a++) write_px(a, $urandom_range(0, 15));
        swap_req = 1'b1;
        run(20);
        swap_req = 1'b0;
        run(FR * TD);

        // Request raised mid row 1: ack only at the next frame boundary.
        cnt = 0;
        while (((t / TD) % FR) != 8 && cnt < FR * TD) begin
            step();
            cnt++;
        end
        swap_wait(FR * TD + 8);
        run(FR * TD);

        // Write landing in the swap_ack cycle is displayed.
        swap_req = 1'b1;
        last_ack = 1'b0;
        for (int i = 0; i < FR * TD + 8; i++) begin
            if (swap_edge(t + 1)) begin
                wr_en = 1'b1;
                wr_addr = 4'd0;
                wr_data = BW'(15);
            end
            step();
            wr_en = 1'b0;
            if (last_ack) break;
        end
        swap_req = 1'b0;
        chk("ack_cycle_write_swap", 32'(last_ack), 32'd1);
        cnt = 0;
        for (int i = 0; i < FR * TD; i++) begin
            step();
            if (aled === 4'b0001 && kled_tri[0] === 1'b1) cnt++;
        end
        chk("ack_cycle_write_lit", 32'(cnt), 32'(15 * TD));

        // Random writes and swap requests.
        for (int i = 0; i < 2000; i++) begin
            if (last_ack) swap_req = 1'b0;
            wr_en = ($urandom_range(0, 3) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = BW'($urandom);
            if (!swap_req && $urandom_range(0, 99) == 0) swap_req = 1'b1;
            else if (swap_req && $urandom_range(0, 299) == 0) swap_req = 1'b0;
            step();
        end
        wr_en = 1'b0;
        swap_req = 1'b0;

        // Reset in the middle of a drive, then the idle scan restarts dark.
        for (int a = 0; a < 16; a++) write_px(a, 15);
        swap_wait(FR * TD + 8);
        run(4 * TD + 1);
        do_reset();
        run(2 * FR * TD + 8);

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
